// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state type and default constants for the uart tx arbiter
package uart_arb_pkg;

    localparam int NUM_REQ_DEFAULT      = 4;
    localparam int TIMEOUT_CLKS_DEFAULT = 12000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uart-side signal bundle of the uart tx arbiter
// master: requesters plus uart_tx (drive requests, see acks/start pulse)
// slave : the arbiter (drives ack, tx start, status)
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_byte;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 tx_active;
    logic                 tx_done;
    logic [IDX_W-1:0]     grant_id;
    logic                 busy;
    logic                 timeout;

    modport master (
        output req, req_byte, req_last, tx_active, tx_done,
        input  ack, tx_dv, tx_byte, grant_id, busy, timeout
    );

    modport slave (
        input  req, req_byte, req_last, tx_active, tx_done,
        output ack, tx_dv, tx_byte, grant_id, busy, timeout
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// rtl/uart_rr_arbiter.sv - combinational round-robin pick starting after the last granted index
// Ports: i_req request vector, i_ptr last granted index, i_mask allowed requesters;
//        o_gnt one-hot grant, o_idx granted index, o_valid some requester granted.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    input  logic [NUM_REQ-1:0]         i_mask,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_valid
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] avail;
    logic [IDX_W-1:0]   cand;

    assign avail = i_req & i_mask;

    // Walk ptr+1 .. ptr+NUM_REQ (the last one wraps back to ptr itself);
    // the first available candidate wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        cand    = '0;
        for (int j = 1; j <= NUM_REQ; j++) begin
            cand = IDX_W'((int'(i_ptr) + j) % NUM_REQ);
            if (!o_valid && avail[cand]) begin
                o_valid     = 1'b1;
                o_idx       = cand;
                o_gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among NUM_REQ requesters
// Ports: i_clk, i_rst_n (synchronous, active-low);
//        requesters: i_req, i_req_byte, i_req_last -> o_ack;
//        uart_tx: o_tx_dv, o_tx_byte -> i_tx_active, i_tx_done;
//        status: o_grant_id, o_busy, o_timeout.
// Optional macro UART_ARB_LOCK_EN: a requester keeps the channel until it sends i_req_last.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEFAULT,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT
)(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [8*NUM_REQ-1:0]       i_req_byte,
    input  logic [NUM_REQ-1:0]         i_req_last,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic                       o_tx_dv,
    output logic [7:0]                 o_tx_byte,
    input  logic                       i_tx_active,
    input  logic                       i_tx_done,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_busy,
    output logic                       o_timeout
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_dv_q, tx_dv_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic               timeout_q, timeout_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic [NUM_REQ-1:0] arb_mask;
    logic [7:0]         sel_byte;

`ifdef UART_ARB_LOCK_EN
    // All ones = unlocked; otherwise one-hot of the requester holding the channel.
    logic [NUM_REQ-1:0] lock_mask_q, lock_mask_d;
    assign arb_mask = lock_mask_q;
`else
    logic unused_req_last;
    assign arb_mask        = '1;
    assign unused_req_last = ^i_req_last;
`endif

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .i_mask  (arb_mask),
        .o_gnt   (gnt),
        .o_idx   (gnt_idx),
        .o_valid (gnt_valid)
    );

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) sel_byte = i_req_byte[k*8 +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        grant_id_d = grant_id_q;
        timeout_d  = 1'b0;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
`ifdef UART_ARB_LOCK_EN
        lock_mask_d = lock_mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_valid && !i_tx_active) begin
                    state_d    = SEND;
                    ack_d      = gnt;
                    tx_byte_d  = sel_byte;
                    grant_id_d = gnt_idx;
                    ptr_d      = gnt_idx;
`ifdef UART_ARB_LOCK_EN
                    lock_mask_d = (|(i_req_last & gnt)) ? '1 : gnt;
`endif
                end
            end
            SEND: begin
                // A done pulse arriving here belongs to nothing we started.
                state_d = WAIT_DONE;
                tx_dv_d = 1'b1;
                cnt_d   = '0;
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
`ifdef UART_ARB_LOCK_EN
                    lock_mask_d = '1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            grant_id_q <= '0;
            timeout_q  <= 1'b0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            cnt_q      <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_mask_q <= '1;
`endif
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            grant_id_q <= grant_id_d;
            timeout_q  <= timeout_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
`ifdef UART_ARB_LOCK_EN
            lock_mask_q <= lock_mask_d;
`endif
        end
    end

    assign o_ack      = ack_q;
    assign o_tx_dv    = tx_dv_q;
    assign o_tx_byte  = tx_byte_q;
    assign o_grant_id = grant_id_q;
    assign o_timeout  = timeout_q;
    assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a behavioural reference model
module tb_uart_tx_arbiter;

    localparam int N            = 4;
    localparam int T            = 100;
    localparam int CLKS_PER_BIT = 8;
    localparam int FRAME        = 10 * CLKS_PER_BIT;

    logic clk = 1'b0;
    logic rst_n;
    always #50 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CLKS(T)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (bus.req),
        .i_req_byte  (bus.req_byte),
        .i_req_last  (bus.req_last),
        .o_ack       (bus.ack),
        .o_tx_dv     (bus.tx_dv),
        .o_tx_byte   (bus.tx_byte),
        .i_tx_active (bus.tx_active),
        .i_tx_done   (bus.tx_done),
        .o_grant_id  (bus.grant_id),
        .o_busy      (bus.busy),
        .o_timeout   (bus.timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [8:0] rq [N][$];
    logic [7:0] rx_log [$];
    int  stub_left   = 0;
    bit  stub_mute   = 0;
    bit  noise_en    = 0;
    bit  force_mode  = 0;
    bit  random_mode = 0;

    // reference model: expected visible outputs plus transaction age
    // (0 = idle, 1 = accept cycle, 2 = start pulse, >=2 waiting for done)
    logic [N-1:0] e_ack;
    logic         e_dv, e_busy, e_to;
    logic [7:0]   e_byte;
    int           e_gid;
    int           age, m_ptr, m_lock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit queues_empty();
        for (int k = 0; k < N; k++) if (rq[k].size() != 0) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_log.size()) return {24'h0, rx_log[i]};
        return 32'hxxxx_xxxx;
    endfunction

    task automatic drive_env();
        for (int k = 0; k < N; k++) begin
            if (bus.ack[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            bus.req[k]            = (rq[k].size() > 0);
            bus.req_byte[k*8 +: 8] = (rq[k].size() > 0) ? rq[k][0][7:0] : 8'h00;
            bus.req_last[k]       = (rq[k].size() > 0) ? rq[k][0][8] : 1'b0;
        end
        if (bus.tx_dv) begin
            rx_log.push_back(bus.tx_byte);
            stub_left = FRAME;
            if (random_mode) stub_mute = ($urandom_range(0, 15) == 0);
        end
        bus.tx_active = (stub_left > 0);
        bus.tx_done   = (stub_left == 1 && !stub_mute)
                      || (noise_en && $urandom_range(0, 39) == 0)
                      || (force_mode && age == T + 1);
        if (stub_left > 0) stub_left--;
    endtask

    task automatic model_step();
        int pick;
        e_ack = '0;
        e_dv  = 1'b0;
        e_to  = 1'b0;
        if (!rst_n) begin
            e_busy = 0; e_byte = 8'h00; e_gid = 0;
            age = 0; m_ptr = N - 1; m_lock = -1;
            return;
        end
        if (age == 0) begin
            pick = -1;
            if (!bus.tx_active) begin
                for (int j = 1; j <= N; j++) begin
                    int idx = (m_ptr + j) % N;
                    if (pick < 0 && bus.req[idx] && (m_lock < 0 || m_lock == idx)) pick = idx;
                end
            end
            if (pick >= 0) begin
                e_ack[pick] = 1'b1;
                e_byte      = bus.req_byte[pick*8 +: 8];
                e_gid       = pick;
                m_ptr       = pick;
                age         = 1;
                e_busy      = 1;
`ifdef UART_ARB_LOCK_EN
                m_lock = bus.req_last[pick] ? -1 : pick;
`endif
            end else begin
                e_busy = 0;
            end
        end else if (age == 1) begin
            e_dv   = 1;
            age    = 2;
            e_busy = 1;
        end else if (bus.tx_done) begin
            age    = 0;
            e_busy = 0;
        end else if (age - 2 == T - 1) begin
            e_to   = 1;
            age    = 0;
            e_busy = 0;
            m_lock = -1;
        end else begin
            age++;
        end
    endtask

    task automatic tick();
        drive_env();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("ack",      {28'h0, bus.ack},      {28'h0, e_ack});
        check("tx_dv",    {31'h0, bus.tx_dv},    {31'h0, e_dv});
        check("tx_byte",  {24'h0, bus.tx_byte},  {24'h0, e_byte});
        check("grant_id", {30'h0, bus.grant_id}, e_gid);
        check("busy",     {31'h0, bus.busy},     {31'h0, e_busy});
        check("timeout",  {31'h0, bus.timeout},  {31'h0, e_to});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((bus.busy || bus.tx_active || !queues_empty()) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drain"}, n < budget, 1);
    endtask

    task automatic wait_for_ack(input int budget, output int n);
        n = 0;
        do begin tick(); n++; end while (bus.ack == '0 && n < budget);
    endtask

    task automatic wait_for_dv(input int budget, output int n);
        n = 0;
        do begin tick(); n++; end while (!bus.tx_dv && n < budget);
    endtask

    initial begin
        #(60000 * 100);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, dv_cyc, to_cyc, to_seen;
        rst_n = 1'b0;
        bus.req = '0; bus.req_byte = '0; bus.req_last = '0;
        bus.tx_active = 1'b0; bus.tx_done = 1'b0;
        age = 0; m_ptr = N - 1; m_lock = -1;
        e_ack = '0; e_dv = 0; e_busy = 0; e_to = 0; e_byte = 0; e_gid = 0;
        @(negedge clk);
        do_reset();
        check("rst_busy",    {31'h0, bus.busy},     0);
        check("rst_ack",     {28'h0, bus.ack},      0);
        check("rst_tx_dv",   {31'h0, bus.tx_dv},    0);
        check("rst_tx_byte", {24'h0, bus.tx_byte},  0);
        check("rst_gid",     {30'h0, bus.grant_id}, 0);
        check("rst_timeout", {31'h0, bus.timeout},  0);

        // single request from requester 2
        rx_log.delete();
        rq[2].push_back({1'b1, 8'hA5});
        wait_for_ack(20, n);
        check("single_ack_latency", n, 1);
        check("single_ack", {28'h0, bus.ack}, 32'h4);
        check("single_gid", {30'h0, bus.grant_id}, 2);
        tick();
        check("single_dv", {31'h0, bus.tx_dv}, 1);
        tick();
        check("single_dv_one_cycle", {31'h0, bus.tx_dv}, 0);
        wait_idle("single", 300);
        check("single_rx", rx_at(0), 32'hA5);

        // contention, all four held
        do_reset();
        rx_log.delete();
        for (int k = 0; k < N; k++) begin
            rq[k].push_back({1'b1, 8'(8'h10 + k)});
            rq[k].push_back({1'b1, 8'(8'h10 + k)});
        end
        wait_idle("contention", 2000);
        check("cont_rx0", rx_at(0), 32'h10);
        check("cont_rx1", rx_at(1), 32'h11);
        check("cont_rx2", rx_at(2), 32'h12);
        check("cont_rx3", rx_at(3), 32'h13);
        check("cont_rx4", rx_at(4), 32'h10);

        // timeout with uart done suppressed
        stub_mute = 1;
        rq[1].push_back({1'b1, 8'h77});
        wait_for_dv(20, n);
        dv_cyc = cyc;
        n = 0;
        do begin tick(); n++; end while (!bus.timeout && n < 200);
        to_cyc = cyc;
        check("timeout_delay", to_cyc - dv_cyc, T);
        check("timeout_idle", {31'h0, bus.busy}, 0);
        wait_idle("timeout", 300);

        // done and timeout in the same cycle: done wins
        force_mode = 1;
        rq[3].push_back({1'b1, 8'h78});
        wait_for_dv(20, n);
        dv_cyc = cyc;
        to_seen = 0;
        n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
            if (bus.timeout) to_seen++;
        end
        check("tie_no_timeout", to_seen, 0);
        check("tie_idle_delay", cyc - dv_cyc, T);
        force_mode = 0;
        stub_mute = 0;
        wait_idle("tie", 300);

        // reset in the middle of WAIT_DONE
        rq[3].push_back({1'b1, 8'h55});
        wait_for_dv(20, n);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy",    {31'h0, bus.busy},     0);
        check("mid_rst_tx_byte", {24'h0, bus.tx_byte},  0);
        check("mid_rst_gid",     {30'h0, bus.grant_id}, 0);
        check("mid_rst_ack",     {28'h0, bus.ack},      0);
        for (int k = 0; k < N; k++) rq[k].push_back({1'b1, 8'(8'h60 + k)});
        wait_for_ack(200, n);
        check("mid_rst_next_grant", {28'h0, bus.ack}, 32'h1);
        wait_idle("mid_rst", 2000);

        // packet lock
        do_reset();
        rx_log.delete();
        rq[1].push_back({1'b0, 8'h41});
        tick();
        rq[1].push_back({1'b1, 8'h42});
        rq[0].push_back({1'b1, 8'h30});
        wait_idle("lock", 1000);
        check("lock_rx0", rx_at(0), 32'h41);
`ifdef UART_ARB_LOCK_EN
        check("lock_rx1", rx_at(1), 32'h42);
        check("lock_rx2", rx_at(2), 32'h30);
`else
        check("lock_rx1", rx_at(1), 32'h30);
        check("lock_rx2", rx_at(2), 32'h42);
`endif

        // randomized traffic against the model
        random_mode = 1;
        noise_en    = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                int k = $urandom_range(0, N - 1);
                if (rq[k].size() < 3) rq[k].push_back(9'($urandom));
            end
            if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
        random_mode = 0;
        noise_en    = 0;
        stub_mute   = 0;
        do_reset();
        wait_idle("random", 5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
